// File: rtl/sn74ls148_seq.sv
// sn74ls148_seq: synchronized 8-to-3 priority encoder with a valid/ack handshake, modelled on the '148.
// Define LS148_EDGE_CAPTURE_EN for sticky falling-edge request capture; the default is level capture.
module sn74ls148_seq #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       EI_n,
   input  logic       I0_n,
   input  logic       I1_n,
   input  logic       I2_n,
   input  logic       I3_n,
   input  logic       I4_n,
   input  logic       I5_n,
   input  logic       I6_n,
   input  logic       I7_n,
   input  logic       ack,
   output logic       A0_n,
   output logic       A1_n,
   output logic       A2_n,
   output logic       GS_n,
   output logic       EO_n,
   output logic       valid,
   output logic [7:0] pending
);
   typedef enum logic {IDLE, HOLD} state_t;
   state_t state, state_nx;
   logic [SYNC_STAGES-1:0][8:0] sr;
   logic [8:0] sync_v;
   logic       ei_s;
   logic [7:0] req, pend_nx;
   logic [2:0] code, top;
   // bit 8 carries EI_n so enable and requests see identical latency
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sr <= '1;
      else        sr <= {sr[SYNC_STAGES-2:0], {EI_n, I7_n, I6_n, I5_n, I4_n, I3_n, I2_n, I1_n, I0_n}};
   assign sync_v = sr[SYNC_STAGES-1];
   assign ei_s   = sync_v[8];
   assign req    = ~sync_v[7:0];
`ifdef LS148_EDGE_CAPTURE_EN
   logic [7:0] prev;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) prev <= '1;
      else        prev <= sync_v[7:0];
   // set is OR'd after the clear so a coincident new request survives the ack
   always_comb
      pend_nx = (pending & ~((state == HOLD && ack) ? (8'b1 << code) : 8'h00)) | (prev & req);
`else
   always_comb pend_nx = req;
`endif
   always_comb begin
      top = 3'd0;
      for (int b = 0; b < 8; b++) if (pending[b]) top = 3'(b);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   always_comb
      state_nx = (state == IDLE) ? ((!ei_s && |pending) ? HOLD : IDLE) : (ack ? IDLE : HOLD);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         pending <= 8'h00;
         code    <= 3'd0;
      end else begin
         pending <= pend_nx;
         code    <= (state == IDLE && state_nx == HOLD) ? top : code;
      end
   always_comb begin
      valid              = (state == HOLD);
      {A2_n, A1_n, A0_n} = valid ? ~code : 3'b111;
      GS_n               = ~valid;
      EO_n               = valid | ei_s | (|pending);
   end
endmodule
